longmul_wb_seq: RTL
===================

Name: longmul_wb_seq

Overview:
- Write-back sequencer that drives the single register-file write port on behalf of the multiply unit.
- Splits a 64-bit SMULL/UMULL/SMLAL/UMLAL result into two sequential 32-bit writes, RdLo first and then RdHi.
- For accumulate forms, it first reads RdLo/RdHi through the register-file read ports and adds them to the product.
- 32-bit MUL/MLA results pass through as a single write.

Parameters:
- AW, 4, register address width
- DW, 32, register data width (the 64-bit result is 2*DW)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  result available from the multiply unit
- req_ready  out  1  sequencer can accept; combinational, equals (state==IDLE)
- req_long  in  1  1 = 64-bit long multiply; 0 = 32-bit result
- req_acc  in  1  1 = accumulate form (UMLAL/SMLAL); ignored when req_long=0
- req_lo_addr  in  AW  RdLo (RdLo is the only destination when req_long=0)
- req_hi_addr  in  AW  RdHi
- req_result  in  2*DW  product; only [DW-1:0] is used when req_long=0
- rf_ra1  out  AW  read address A, driven to RdLo in ACC_RD, else 0
- rf_ra2  out  AW  read address B, driven to RdHi in ACC_RD, else 0
- rf_rd1  in  DW  read data A (combinational from the register file)
- rf_rd2  in  DW  read data B
- rf_we  out  1  register-file write enable
- rf_wa  out  AW  write address
- rf_wd  out  DW  write data
- busy  out  1  high whenever state!=IDLE
- done  out  1  one-cycle pulse during the final write beat of a request
- err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Handshake
  - A request is accepted on a rising edge where req_valid=1 and req_ready=1.
  - At acceptance, all req_* fields are latched into internal registers: lo_q, hi_q, res_q[2*DW-1:0], long_q, acc_q.
- States: IDLE, ACC_RD, WR_LO, WR_HI.
- Transitions from IDLE on acceptance:
  - If either used address equals 4'b1111, the request is rejected: err=1 in the next cycle, state stays IDLE, and no writes or reads occur. For req_long=0 only req_lo_addr is checked.
  - Else if long=1 and acc=1, go to ACC_RD.
  - Else go to WR_LO.
- ACC_RD (1 cycle)
  - rf_ra1=lo_q and rf_ra2=hi_q.
  - At the edge, res_q <= {rf_rd2, rf_rd1} + res_q, modulo 2^(2*DW); the carry-out is discarded.
  - Next state: WR_LO.
- WR_LO (1 cycle)
  - rf_we=1, rf_wa=lo_q, rf_wd=res_q[DW-1:0].
  - Next state is WR_HI if long_q, else IDLE with done=1 in this cycle.
- WR_HI (1 cycle)
  - rf_we=1, rf_wa=hi_q, rf_wd=res_q[2*DW-1:DW].
  - done=1 in this cycle; next state is IDLE.
- Latency from the acceptance edge T:
  - 32-bit: write beat in cycle T+1.
  - Long: write beats in cycles T+1 and T+2.
  - Long accumulate: read in T+1, writes in T+2 and T+3.
  - req_ready returns high in the cycle after the final write beat, so back-to-back requests have no bubble beyond that.
- Outside the write states: rf_we=0, rf_wa=0, rf_wd=0.
- Aliasing
  - lo_q==hi_q in long mode: both beats are issued, so the RdHi value is left in the register.
  - In accumulate mode with aliasing, rf_rd1 and rf_rd2 return the same register, and the sum uses that value twice.
- req_valid deasserting while busy has no effect; latched fields govern the operation.
- Reset
  - Asynchronous: forces state IDLE and rf_we=0, rf_wa=0, rf_wd=0, done=0, err=0, busy=0, and clears all latched registers to 0. Consequently req_ready=1.
  - Reset after the WR_LO beat leaves RdLo written and RdHi unchanged; no recovery is attempted.

Test Plan:
- 32-bit write: lo=3, result=64'h0000_0000_DEAD_BEEF, long=0 -> one beat in T+1 with rf_we=1, wa=3, wd=32'hDEADBEEF, done=1; req_ready=1 in T+2.
- UMULL: lo=4, hi=5, result=64'h1234_5678_9ABC_DEF0 -> T+1: wa=4, wd=9ABCDEF0; T+2: wa=5, wd=12345678, done=1; busy high for 2 cycles.
- UMLAL with wrap: rf_rd1=FFFF_FFFF (R4), rf_rd2=FFFF_FFFF (R5), result=64'h1 -> T+1: ra1=4, ra2=5, rf_we=0; T+2: wd=0000_0000; T+3: wd=0000_0000 (carry dropped).
- UMLAL with carry: rd1=FFFF_FFFF, rd2=0, result=1 -> writes lo=0, hi=1.
- PC destination: hi=15, long=1 -> err pulses in T+1, rf_we never asserts, req_ready stays 1.
- Reset mid-op: assert reset during WR_HI -> rf_we, done and busy drop immediately; only the RdLo write completed; the next request is accepted normally after reset releases.

Source files
------------

// File: rtl/longmul_wb_seq_if.sv
// Request and register-file port bundle for the multiply write-back sequencer.
interface longmul_wb_seq_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_long;
  logic            req_acc;
  logic [AW-1:0]   req_lo_addr;
  logic [AW-1:0]   req_hi_addr;
  logic [2*DW-1:0] req_result;
  logic [AW-1:0]   rf_ra1;
  logic [AW-1:0]   rf_ra2;
  logic [DW-1:0]   rf_rd1;
  logic [DW-1:0]   rf_rd2;
  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [DW-1:0]   rf_wd;
  logic            busy;
  logic            done;
  logic            err;

  // Multiply unit plus register file side
  modport master (
    output req_valid, req_long, req_acc, req_lo_addr, req_hi_addr, req_result,
    output rf_rd1, rf_rd2,
    input  req_ready, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_long, req_acc, req_lo_addr, req_hi_addr, req_result,
    input  rf_rd1, rf_rd2,
    output req_ready, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd, busy, done, err
  );
endinterface

// File: rtl/longmul_wb_seq.sv
// Sequences a multiply result onto the single register-file write port,
// splitting 64-bit results into RdLo/RdHi beats with optional accumulate read.
module longmul_wb_seq #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) (
  input  logic               clk,
  input  logic               reset,
  longmul_wb_seq_if.slave    bus
);
  localparam int unsigned RW = 2 * DW;
  localparam logic [AW-1:0] PC_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {IDLE, ACC_RD, WR_LO, WR_HI} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [RW-1:0] res_q, res_d;
  logic          long_q, long_d, acc_q, acc_d;

  logic          we_q, we_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [AW-1:0] wa_q, wa_d, ra1_q, ra1_d, ra2_q, ra2_d;
  logic [DW-1:0] wd_q, wd_d;

  logic          bad_addr;

  // A request targeting the PC is rejected; the high address only matters for long forms
  assign bad_addr = (bus.req_lo_addr == PC_ADDR) ||
                    (bus.req_long && (bus.req_hi_addr == PC_ADDR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      res_q   <= '0;
      long_q  <= 1'b0;
      acc_q   <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      res_q   <= res_d;
      long_q  <= long_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, latched fields, and the port values for the state being entered
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    res_d   = res_q;
    long_d  = long_q;
    acc_d   = acc_q;
    err_d   = 1'b0;
    we_d    = 1'b0;
    wa_d    = '0;
    wd_d    = '0;
    ra1_d   = '0;
    ra2_d   = '0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          lo_d   = bus.req_lo_addr;
          hi_d   = bus.req_hi_addr;
          res_d  = bus.req_result;
          long_d = bus.req_long;
          acc_d  = bus.req_acc;
          if (bad_addr)                         err_d   = 1'b1;
          else if (bus.req_long && bus.req_acc) state_d = ACC_RD;
          else                                  state_d = WR_LO;
        end
      end
      ACC_RD: begin
        res_d   = RW'({bus.rf_rd2, bus.rf_rd1} + res_q);
        state_d = WR_LO;
      end
      WR_LO:   state_d = long_q ? WR_HI : IDLE;
      WR_HI:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    unique case (state_d)
      ACC_RD: begin
        ra1_d = lo_d;
        ra2_d = hi_d;
      end
      WR_LO: begin
        we_d   = 1'b1;
        wa_d   = lo_d;
        wd_d   = res_d[DW-1:0];
        done_d = ~long_d;
      end
      WR_HI: begin
        we_d   = 1'b1;
        wa_d   = hi_d;
        wd_d   = res_d[RW-1:DW];
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rf_ra1    = ra1_q;
  assign bus.rf_ra2    = ra2_q;
  assign bus.rf_we     = we_q;
  assign bus.rf_wa     = wa_q;
  assign bus.rf_wd     = wd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
